// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer controller: state encoding
// and prescaler width helper.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_PAUSE   = 2'b10,
    ST_EXPIRED = 2'b11
  } state_e;

  // Width needed to count 0..div-1; never less than one bit.
  function automatic int presc_w(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/countdown_ctrl_tick_prescaler.sv
// Enable-gated prescaler: counts 0..TICK_DIV-1 while en is high and flags a
// step in the cycle that holds TICK_DIV-1, so the consumer acts on that edge.
module tick_prescaler
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int            PW   = presc_w(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // Next phase: clear wins, otherwise advance and wrap only while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Phase register; holds its value while disabled so pause keeps partial time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign step = en && (cnt_q == LAST);

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown timer controller: IDLE/RUN/PAUSE/EXPIRED sequencer driving a
// down-counter from a shared prescaler; all outputs come straight from flops.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] preset,
  input  logic             start,
  input  logic             pause,
  output logic [CNT_W-1:0] remaining,
  output logic [1:0]       state,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic             alarm
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             alarm_q, alarm_d;
  logic             step_s;
  logic             presc_clr_s;
  logic             dec_s;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == ST_RUN),
    .clr  (presc_clr_s),
    .step (step_s)
  );

  // State, count and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      alarm_q <= alarm_d;
    end
  end

  // Next state and count; command priority clr > load > start > pause.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    presc_clr_s = 1'b0;
    dec_s       = 1'b0;
    if (clr) begin
      state_d     = ST_IDLE;
      rem_d       = '0;
      presc_clr_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            rem_d       = preset;
            presc_clr_s = 1'b1;
          end else if (start && (rem_q != '0)) begin
            state_d     = ST_RUN;
            presc_clr_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          // A step on the same edge as pause still lands; reaching zero beats pause.
          if (step_s && (rem_q != '0)) begin
            dec_s = 1'b1;
            rem_d = rem_q - CNT_ONE;
            if (rem_q == CNT_ONE) begin
              state_d = ST_EXPIRED;
            end else if (pause) begin
              state_d = ST_PAUSE;
            end else begin
              state_d = ST_RUN;
            end
          end else if (pause) begin
            state_d = ST_PAUSE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (load) begin
            rem_d       = preset;
            presc_clr_s = 1'b1;
          end else if (start) begin
            state_d = (rem_q != '0) ? ST_RUN : ST_IDLE;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_EXPIRED: begin
          if (load) begin
            rem_d       = preset;
            state_d     = ST_IDLE;
            presc_clr_s = 1'b1;
          end else begin
            state_d = ST_EXPIRED;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          rem_d       = '0;
          presc_clr_s = 1'b1;
        end
      endcase
    end
  end

  // Output values for the next cycle, derived from the transition being taken.
  always_comb begin
    tick_d  = dec_s;
    done_d  = dec_s && (rem_d == '0);
    busy_d  = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    alarm_d = (state_d == ST_EXPIRED);
  end

  assign remaining = rem_q;
  assign state     = state_q;
  assign busy      = busy_q;
  assign tick      = tick_q;
  assign done      = done_q;
  assign alarm     = alarm_q;

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Programmable countdown-timer controller: sequences an internal enable-based prescaler and a down-counter for seconds-style countdowns.
- Prescaler is shared with the sequencer; pause holds its phase, so resume does not lose partial time.
- Produces tick, done and alarm indications for display/LED logic.
- Single clock domain; no derived clocks; all timing via one-cycle enables.

Parameters:
- TICK_DIV, 50000000, clk cycles per countdown step (1 s at 50 MHz); must be >= 2.
- CNT_W, 8, width of preset/remaining.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear, level-sampled each cycle.
- load  in  1  load preset into remaining.
- preset  in  CNT_W  countdown start value, sampled when load is accepted.
- start  in  1  start, or resume from pause.
- pause  in  1  pause request.
- remaining  out  CNT_W  current count.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 EXPIRED.
- busy  out  1  high in RUN or PAUSE.
- tick  out  1  one-cycle pulse per decrement.
- done  out  1  one-cycle pulse on reaching 0.
- alarm  out  1  level, high in EXPIRED.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, remaining=0, prescaler=0.
  - tick=done=alarm=busy=0.
- All outputs are registered.
- Command priority within a cycle: clr > load > start > pause.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while state=RUN.
  - At TICK_DIV-1 it wraps to 0 and issues an internal step.
  - Holds its value in PAUSE.
  - Cleared to 0 by clr, by any accepted load, and by start from IDLE.
- IDLE:
  - load: remaining<=preset, stay IDLE.
  - start with remaining!=0: go to RUN.
  - start with remaining==0: ignored.
  - pause: ignored.
- RUN:
  - On step: remaining<=remaining-1 and tick=1 in the same cycle the new value is visible.
  - If the step brings remaining to 0: state<=EXPIRED, done=1 and alarm=1, all in that same cycle.
  - pause: state<=PAUSE.
    - A step occurring on the same edge is still applied.
    - If that step reaches 0, EXPIRED wins over PAUSE.
  - load and start: ignored.
- PAUSE:
  - start: back to RUN with prescaler phase retained.
  - load: remaining<=preset, prescaler<=0, stay PAUSE.
  - If a load in PAUSE sets remaining=0, a later start moves to IDLE instead of RUN; no done pulse.
- EXPIRED:
  - alarm held high.
  - load: remaining<=preset, state<=IDLE, alarm<=0.
  - start and pause: ignored.
- clr in any state: state<=IDLE, remaining<=0, prescaler<=0, alarm<=0; no done or tick pulse.
- Latency: start accepted at edge k puts state=RUN after edge k; the first tick and decrement appear after edge k+TICK_DIV. Each later step follows TICK_DIV cycles after the previous one.
- Width: remaining never wraps below 0. A decrement is only possible when remaining>=1.
- Reset mid-operation: asynchronous return to the reset values above; no pulse is generated.

Decomposition:
- Package countdown_pkg:
  - State encoding constants ST_IDLE, ST_RUN, ST_PAUSE, ST_EXPIRED.
  - PRESC_W = clog2(TICK_DIV) helper.
- Sub-module tick_prescaler:
  - Inputs: clk, rst, en, clr.
  - Output: step pulse.
  - Parameter: TICK_DIV.
- countdown_ctrl holds the FSM, the remaining register and the output registers.

Test Plan (TICK_DIV=4, CNT_W=8):
- Basic countdown: load preset=3, then start.
  - tick pulses 4, 8 and 12 cycles after start; remaining goes 2,1,0.
  - done=1 only with remaining=0; alarm stays 1 and state=11.
- Pause/resume phase: load 5, start, pause 2 cycles after start, hold 10 cycles, start.
  - First tick comes 2 cycles after resume; remaining=4.
  - No tick during pause.
- Collision: pause asserted on the same edge as the final step (remaining 1->0).
  - state=EXPIRED, done=1; PAUSE is never entered.
- Priorities:
  - clr+load+start together in RUN: IDLE with remaining=0.
  - load+start in IDLE with preset=7: remaining=7, state stays IDLE.
  - A following start enters RUN.
- Zero cases:
  - start with remaining=0 in IDLE: state stays 00, busy=0.
  - In EXPIRED, load 9: IDLE, alarm=0, remaining=9.
- Async reset mid-RUN (remaining=6): all outputs go to 0 immediately.
  - After reset release with no further commands: no tick for 20 cycles.
